jam_param_engine: RTL and testbench
===================================

// Module: jam_param_engine
// PURPOSE
//   Parametrised job-assignment engine, successor to the fixed 8x8 JAM core.
//   Exhaustively enumerates all N! worker->job permutations in lexicographic order, fetching costs from
//   an external combinational cost ROM via W/J. Reports the minimum total cost and how many permutations reach it.
//   Adds a Start/Busy handshake, so back-to-back problems run without reset.
// PARAMETERS
//   N       8   workers = jobs; legal range 2..8
//   COST_W  7   width of one cost entry
//   CNT_W   16  MatchCount width; saturates at all-ones
//   localparam IDX_W = $clog2(N); SUM_W = COST_W + $clog2(N) (N=8, COST_W=7 -> 10)
// PORTS
//   CLK         in   1        clock, rising edge
//   RST         in   1        reset, synchronous, active-high
//   Start       in   1        request a new search; sampled only in IDLE
//   Busy        out  1        high from the cycle after Start is accepted until DONE
//   W           out  IDX_W    worker index to cost ROM
//   J           out  IDX_W    job index to cost ROM
//   Cost        in   COST_W   cost[W][J]; combinational, valid in the same cycle as W/J
//   MinCost     out  SUM_W    minimum total cost
//   MatchCount  out  CNT_W    number of permutations with total == MinCost
//   Valid       out  1        one-cycle pulse; MinCost/MatchCount valid
// BEHAVIOUR
//   Reset: state IDLE; W=J=0; MinCost=0; MatchCount=0; Valid=0; Busy=0; perm[i]=i.
//   RST mid-search aborts immediately to the reset state. No Valid is issued for the aborted search.
//   FSM: IDLE -> ACC -> CMP -> PIVOT -> (SWAP -> REV -> ACC) | DONE -> IDLE
//   IDLE : on Start=1: perm<=identity, sum<=0, min<=all-ones, cnt<=0, i<=0; go ACC. Start is ignored in other states.
//   ACC  : N cycles; W=i, J=perm[i], sum+=Cost; i counts 0..N-1.
//   CMP  : 1 cycle. sum<min -> min<=sum, cnt<=1.
//          sum==min -> cnt<=cnt+1, saturating at 2^CNT_W-1.
//   PIVOT: 1 cycle. Find largest k with perm[k]<perm[k+1]. If none, go DONE; else go SWAP.
//   SWAP : 1 cycle. Swap perm[k] with perm[l], where l is the largest index with perm[l]>perm[k].
//   REV  : 1 cycle. Reverse perm[k+1..N-1]; clear sum and i; go ACC.
//   DONE : MinCost<=min, MatchCount<=cnt, Valid=1 for this single cycle, Busy=0.
//          MinCost/MatchCount then hold until the next accepted Start.
//   Latency: Valid is high L=(N!-1)*(N+4)+N+2 edges after the Start-sampling edge (N=4: 190).
//   Outside ACC, W/J hold their last value (no ROM glitching requirement).
//   Widths: sum is SUM_W and never overflows; all comparisons are unsigned.
//   Ties: every equal-minimum permutation is counted, including the first one found.
// CONFIGURATION
//   JAM_BEST_PERM_EN defined: extra output BestPerm [N*IDX_W-1:0]; slice i = job assigned to worker i.
//     Updated only on strict sum<min, so it reports the lexicographically first optimal permutation.
//     Reset value: identity.
//     Latched into the output register at DONE alongside MinCost.
//   JAM_BEST_PERM_EN undefined: no port and no storage. All other behaviour is identical.
// STRUCTURE
//   jam_pkg: state enum (IDLE, ACC, CMP, PIVOT, SWAP, REV, DONE); fact(N) and sum-width functions;
//     perm_t array typedef.
//   Sub-module jam_perm_next: holds the perm register and provides
//     load_identity, pivot-found/none, swap and reverse controls.
//   Top level: FSM, accumulator, min/count registers, output registers.
// TESTING
//   N=3, cost[w][j]=3w+j -> every permutation sums to 12: MinCost=12, MatchCount=6.
//   N=4, all-zero costs -> MinCost=0, MatchCount=24; Valid exactly 190 edges after Start.
//   N=8, COST_W=7, CNT_W=4, golden cost_rom patterns 1..3 -> MinCost/MatchCount match the golden file.
//   N=8, CNT_W=8, all-zero costs -> MatchCount saturates at 255, MinCost=0.
//   Assert RST 50 cycles into a run -> all outputs at reset values next cycle.
//     New Start -> correct result, with no stale Valid.
//   JAM_BEST_PERM_EN, N=3, cost=diag 0 with 9 elsewhere -> BestPerm={2,1,0} (identity), MinCost=0, MatchCount=1.
//   Second Start issued right after Valid -> second result correct. Start pulses during Busy are ignored.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared types and helpers for the jam_param_engine job-assignment search.
// Optional best-permutation reporting is enabled with JAM_BEST_PERM_EN.
package jam_pkg;

    typedef enum logic [2:0] {IDLE, ACC, CMP, PIVOT, SWAP, REV, DONE} state_t;

    localparam int MAX_N     = 8;
    localparam int MAX_IDX_W = 3;

    typedef logic [MAX_IDX_W-1:0] idx_t;
    typedef idx_t [MAX_N-1:0]     perm_t;

    function automatic int fact(input int n);
        int r;
        r = 1;
        for (int k = 2; k <= n; k++) r = r * k;
        return r;
    endfunction

    // A sum of n entries of cost_w bits fits in cost_w + clog2(n) bits.
    function automatic int sum_width(input int cost_w, input int n);
        return cost_w + $clog2(n);
    endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Permutation register with lexicographic next-permutation steps (pivot, swap, reverse).
// With JAM_BEST_PERM_EN the flattened permutation is exported for best-permutation capture.
module jam_perm_next
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_identity,
    input  logic             latch_pivot,
    input  logic             do_swap,
    input  logic             do_rev,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W-1:0] rd_val,
    output logic             pivot_found
`ifdef JAM_BEST_PERM_EN
    ,output logic [N*IDX_W-1:0] perm_flat
`endif
);

    logic [IDX_W-1:0] perm [N];
    logic [IDX_W-1:0] rev  [N];
    logic [IDX_W-1:0] piv_k;
    logic [IDX_W-1:0] k_reg;
    logic [IDX_W-1:0] swap_l;

    assign rd_val = perm[rd_idx];

    // Ascending scan so the last hit is the largest pivot index.
    always_comb begin
        pivot_found = 1'b0;
        piv_k       = '0;
        for (int k = 0; k < N-1; k++) begin
            if (perm[k] < perm[k+1]) begin
                pivot_found = 1'b1;
                piv_k       = IDX_W'(k);
            end
        end
    end

    always_comb begin
        swap_l = k_reg;
        for (int l = 0; l < N; l++) begin
            if (perm[l] > perm[k_reg]) swap_l = IDX_W'(l);
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            rev[j] = perm[j];
            if (j > int'(k_reg)) rev[j] = perm[IDX_W'(N + int'(k_reg) - j)];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || load_identity) begin
            for (int i = 0; i < N; i++) perm[i] <= IDX_W'(i);
            k_reg <= '0;
        end else if (latch_pivot) begin
            k_reg <= piv_k;
        end else if (do_swap) begin
            perm[k_reg]  <= perm[swap_l];
            perm[swap_l] <= perm[k_reg];
        end else if (do_rev) begin
            for (int i = 0; i < N; i++) perm[i] <= rev[i];
        end
    end

`ifdef JAM_BEST_PERM_EN
    always_comb begin
        for (int i = 0; i < N; i++) perm_flat[i*IDX_W +: IDX_W] = perm[i];
    end
`endif

endmodule

// File: rtl/jam_param_engine.sv
// Exhaustive N! job-assignment search: minimum total cost and number of optimal permutations.
// Define JAM_BEST_PERM_EN to add the BestPerm output (first optimal permutation found).
module jam_param_engine
    import jam_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int COST_W = 7,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = $clog2(N),
    localparam int SUM_W  = sum_width(COST_W, N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    output logic              Busy,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic              Valid
`ifdef JAM_BEST_PERM_EN
    ,output logic [N*IDX_W-1:0] BestPerm
`endif
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] widx;
    logic [SUM_W-1:0] acc_sum;
    logic [SUM_W-1:0] min_sum;
    logic [CNT_W-1:0] match_cnt;
    logic             load_identity, latch_pivot, do_swap, do_rev;
    logic             pivot_found;
`ifdef JAM_BEST_PERM_EN
    logic [N*IDX_W-1:0] perm_flat;
    logic [N*IDX_W-1:0] best_perm;

    function automatic logic [N*IDX_W-1:0] ident_flat();
        logic [N*IDX_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*IDX_W +: IDX_W] = IDX_W'(i);
        return r;
    endfunction
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    jam_perm_next #(.N(N), .IDX_W(IDX_W)) u_perm (
        .CLK           (CLK),
        .RST           (RST),
        .load_identity (load_identity),
        .latch_pivot   (latch_pivot),
        .do_swap       (do_swap),
        .do_rev        (do_rev),
        .rd_idx        (widx),
        .rd_val        (J),
        .pivot_found   (pivot_found)
`ifdef JAM_BEST_PERM_EN
        ,.perm_flat    (perm_flat)
`endif
    );

    assign W = widx;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        load_identity = 1'b0;
        latch_pivot   = 1'b0;
        do_swap       = 1'b0;
        do_rev        = 1'b0;
        case (state)
            IDLE:  if (Start) begin
                       load_identity = 1'b1;
                       state_nxt     = ACC;
                   end
            ACC:   if (widx == IDX_W'(N-1)) state_nxt = CMP;
            CMP:   state_nxt = PIVOT;
            PIVOT: begin
                       latch_pivot = 1'b1;
                       state_nxt   = pivot_found ? SWAP : DONE;
                   end
            SWAP:  begin do_swap = 1'b1; state_nxt = REV; end
            REV:   begin do_rev  = 1'b1; state_nxt = ACC; end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the PIVOT->DONE edge so they are stable while Valid is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            widx       <= '0;
            acc_sum    <= '0;
            min_sum    <= '1;
            match_cnt  <= '0;
            MinCost    <= '0;
            MatchCount <= '0;
            Valid      <= 1'b0;
            Busy       <= 1'b0;
`ifdef JAM_BEST_PERM_EN
            best_perm  <= ident_flat();
            BestPerm   <= ident_flat();
`endif
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    acc_sum   <= '0;
                    min_sum   <= '1;
                    match_cnt <= '0;
                    widx      <= '0;
                    Busy      <= 1'b1;
                end
                ACC: begin
                    acc_sum <= acc_sum + SUM_W'(Cost);
                    if (widx != IDX_W'(N-1)) widx <= widx + 1'b1;
                end
                CMP: begin
                    if (acc_sum < min_sum) begin
                        min_sum   <= acc_sum;
                        match_cnt <= CNT_W'(1);
`ifdef JAM_BEST_PERM_EN
                        best_perm <= perm_flat;
`endif
                    end else if (acc_sum == min_sum) begin
                        match_cnt <= sat_inc(match_cnt);
                    end
                end
                PIVOT: if (!pivot_found) begin
                    MinCost    <= min_sum;
                    MatchCount <= match_cnt;
                    Valid      <= 1'b1;
                    Busy       <= 1'b0;
`ifdef JAM_BEST_PERM_EN
                    BestPerm   <= best_perm;
`endif
                end
                REV: begin
                    acc_sum <= '0;
                    widx    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_param_engine.sv
// Directed bench for jam_param_engine: an N=3 instance and an N=4 instance with a 4-bit count.
// BestPerm checks are compiled in when JAM_BEST_PERM_EN is defined.
module tb_jam_param_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode3  = 0;
    int mode4  = 0;

    logic       rst3, start3, busy3, valid3;
    logic [1:0] w3, j3;
    logic [6:0] cost3;
    logic [8:0] min3;
    logic [15:0] cnt3;

    logic       rst4, start4, busy4, valid4;
    logic [1:0] w4, j4;
    logic [6:0] cost4;
    logic [8:0] min4;
    logic [3:0] cnt4;
`ifdef JAM_BEST_PERM_EN
    logic [5:0] bp3;
    logic [7:0] bp4;
`endif

    function automatic logic [6:0] rom3(input int mode, input logic [1:0] w, input logic [1:0] j);
        case (mode)
            0:       return 7'(3 * int'(w) + int'(j));
            1:       return (w == j) ? 7'd0 : 7'd9;
            default: return 7'(int'(w) * int'(j));
        endcase
    endfunction

    function automatic logic [6:0] rom4(input int mode, input logic [1:0] w, input logic [1:0] j);
        case (mode)
            0:       return 7'd0;
            1:       return 7'(int'(j) + 1);
            default: return 7'((int'(w) + int'(j)) % 2);
        endcase
    endfunction

    assign cost3 = rom3(mode3, w3, j3);
    assign cost4 = rom4(mode4, w4, j4);

    jam_param_engine #(.N(3), .COST_W(7), .CNT_W(16)) u3 (
        .CLK(clk), .RST(rst3), .Start(start3), .Busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .Valid(valid3)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp3)
`endif
    );

    jam_param_engine #(.N(4), .COST_W(7), .CNT_W(4)) u4 (
        .CLK(clk), .RST(rst4), .Start(start4), .Busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .Valid(valid4)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(bp4)
`endif
    );

    // Returns edges from the Start-sampling edge to Valid, or -1 on timeout.
    task automatic run3(output int lat);
        lat = -1;
        repeat (2) @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (valid3) begin lat = c; break; end
        end
    endtask

    task automatic run4(output int lat);
        lat = -1;
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (valid4) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy4); end
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", valid4); end
        checks++; if (min4 !== 9'd0) begin errors++; $display("FAIL reset_mincost got %0d want 0", min4); end
        checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt4); end
        checks++; if (w4 !== 2'd0 || j4 !== 2'd0) begin errors++; $display("FAIL reset_wj got %0d/%0d want 0/0", w4, j4); end
        checks++; if (busy3 !== 1'b0 || valid3 !== 1'b0) begin errors++; $display("FAIL reset_n3 busy/valid got %0d/%0d want 0/0", busy3, valid3); end
    endtask

    task automatic test_uniform();
        int lat;
        mode3 = 0;
        run3(lat);
        checks++; if (lat != 40) begin errors++; $display("FAIL uniform_latency got %0d want 40", lat); end
        checks++; if (min3 !== 9'd12) begin errors++; $display("FAIL uniform_mincost got %0d want 12", min3); end
        checks++; if (cnt3 !== 16'd6) begin errors++; $display("FAIL uniform_count got %0d want 6", cnt3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL uniform_busy_done got %0d want 0", busy3); end
        @(posedge clk); #1;
        checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL uniform_valid_pulse got %0d want 0", valid3); end
        checks++; if (min3 !== 9'd12 || cnt3 !== 16'd6) begin errors++; $display("FAIL uniform_hold got %0d/%0d want 12/6", min3, cnt3); end
    endtask

    task automatic test_latency_zero();
        int lat;
        mode4 = 0;
        lat   = -1;
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL zero_busy got %0d want 1", busy4); end
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (valid4) begin lat = c; break; end
        end
        checks++; if (lat != 190) begin errors++; $display("FAIL zero_latency got %0d want 190", lat); end
        checks++; if (min4 !== 9'd0) begin errors++; $display("FAIL zero_mincost got %0d want 0", min4); end
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL zero_count_sat got %0d want 15", cnt4); end
    endtask

    task automatic test_saturation();
        int lat;
        mode4 = 1;
        run4(lat);
        checks++; if (lat != 190) begin errors++; $display("FAIL sat_latency got %0d want 190", lat); end
        checks++; if (min4 !== 9'd10) begin errors++; $display("FAIL sat_mincost got %0d want 10", min4); end
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", cnt4); end
    endtask

    task automatic test_parity();
        int lat;
        mode4 = 2;
        run4(lat);
        checks++; if (min4 !== 9'd0) begin errors++; $display("FAIL parity_mincost got %0d want 0", min4); end
        checks++; if (cnt4 !== 4'd4) begin errors++; $display("FAIL parity_count got %0d want 4", cnt4); end
    endtask

    task automatic test_diag();
        int lat;
        mode3 = 1;
        run3(lat);
        checks++; if (min3 !== 9'd0) begin errors++; $display("FAIL diag_mincost got %0d want 0", min3); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL diag_count got %0d want 1", cnt3); end
`ifdef JAM_BEST_PERM_EN
        checks++; if (bp3 !== 6'b10_01_00) begin errors++; $display("FAIL diag_bestperm got %b want 100100", bp3); end
`endif
    endtask

    task automatic test_product();
        int lat;
        mode3 = 2;
        run3(lat);
        checks++; if (min3 !== 9'd1) begin errors++; $display("FAIL product_mincost got %0d want 1", min3); end
        checks++; if (cnt3 !== 16'd1) begin errors++; $display("FAIL product_count got %0d want 1", cnt3); end
`ifdef JAM_BEST_PERM_EN
        checks++; if (bp3 !== 6'b00_01_10) begin errors++; $display("FAIL product_bestperm got %b want 000110", bp3); end
`endif
    endtask

    task automatic test_abort();
        int lat;
        int stale;
        mode4 = 1;
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk) rst4 = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0) begin errors++; $display("FAIL abort_busy_valid got %0d/%0d want 0/0", busy4, valid4); end
        checks++; if (min4 !== 9'd0 || cnt4 !== 4'd0) begin errors++; $display("FAIL abort_results got %0d/%0d want 0/0", min4, cnt4); end
        checks++; if (w4 !== 2'd0 || j4 !== 2'd0) begin errors++; $display("FAIL abort_wj got %0d/%0d want 0/0", w4, j4); end
        @(negedge clk) rst4 = 1'b0;
        stale = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (valid4 || busy4) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL abort_stale_activity got %0d want 0", stale); end
        mode4 = 2;
        run4(lat);
        checks++; if (lat != 190) begin errors++; $display("FAIL abort_rerun_latency got %0d want 190", lat); end
        checks++; if (min4 !== 9'd0 || cnt4 !== 4'd4) begin errors++; $display("FAIL abort_rerun got %0d/%0d want 0/4", min4, cnt4); end
    endtask

    task automatic test_back_to_back();
        int lat;
        mode3 = 0;
        run3(lat);
        checks++; if (min3 !== 9'd12 || cnt3 !== 16'd6) begin errors++; $display("FAIL b2b_first got %0d/%0d want 12/6", min3, cnt3); end
        // Start raised in the DONE cycle must be ignored and taken on the following IDLE edge.
        mode3  = 2;
        start3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start3 = 1'b0;
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0d want 1", busy3); end
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            start3 = (c >= 5 && c <= 7) ? 1'b1 : 1'b0;
            if (valid3) begin lat = c; break; end
        end
        start3 = 1'b0;
        checks++; if (lat != 40) begin errors++; $display("FAIL b2b_latency got %0d want 40", lat); end
        checks++; if (min3 !== 9'd1 || cnt3 !== 16'd1) begin errors++; $display("FAIL b2b_second got %0d/%0d want 1/1", min3, cnt3); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %0d want 0", busy3); end
    endtask

    initial begin
        rst3 = 1'b1; rst4 = 1'b1;
        start3 = 1'b0; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst3 = 1'b0; rst4 = 1'b0;
        test_reset();
        test_uniform();
        test_latency_zero();
        test_saturation();
        test_parity();
        test_diag();
        test_product();
        test_saturation();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
